// File: rtl/bus_dma_master_if.sv
// Valid/ready memory bus between the DMA initiator (master) and a RAM/ROM slave.
// Signal names are written from the master's point of view.
interface bus_dma_master_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] addr_o;
    logic [31:0]       data_o;
    logic [3:0]        sel_o;
    logic              we_o;
    logic [31:0]       data_i;
    logic              req_valid_o;
    logic              req_ready_i;
    logic              rsp_valid_i;
    logic              rsp_ready_o;

    modport master (
        output addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o,
        input  data_i, req_ready_i, rsp_valid_i
    );

    modport slave (
        input  addr_o, data_o, sel_o, we_o, req_valid_o, rsp_ready_o,
        output data_i, req_ready_i, rsp_valid_i
    );
endinterface

// File: rtl/bus_dma_master.sv
// Single-channel word-copy DMA initiator: reads len words from src, writes them to dst.
// Optional DMA_FILL_EN adds a pattern-fill mode that skips the read phase.
module bus_dma_master #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] src_addr_i,
    input  logic [ADDR_W-1:0] dst_addr_i,
    input  logic [LEN_W-1:0]  len_i,
`ifdef DMA_FILL_EN
    input  logic              fill_i,
    input  logic [31:0]       pattern_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    bus_dma_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RSP,
        WR_REQ,
        WR_RSP,
        FIN
    } state_e;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       buf_q, buf_d;
    logic              fill_q, fill_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              req_valid_q, req_valid_d;
    logic              rsp_ready_q, rsp_ready_d;
    logic              done_q, done_d;

    logic              start_fill;
    logic [31:0]       start_pattern;

`ifdef DMA_FILL_EN
    assign start_fill    = fill_i;
    assign start_pattern = pattern_i;
`else
    assign start_fill    = 1'b0;
    assign start_pattern = 32'h0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        fill_d  = fill_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d  = src_addr_i & ALIGN_MASK;
                    dst_d  = dst_addr_i & ALIGN_MASK;
                    cnt_d  = len_i;
                    fill_d = start_fill;
                    buf_d  = start_fill ? start_pattern : buf_q;
                    if (len_i == '0)     state_d = FIN;
                    else if (start_fill) state_d = WR_REQ;
                    else                 state_d = RD_REQ;
                end
            end
            RD_REQ: if (bus.req_ready_i) state_d = RD_RSP;
            RD_RSP: begin
                if (bus.rsp_valid_i) begin
                    buf_d   = bus.data_i;
                    state_d = WR_REQ;
                end
            end
            WR_REQ: if (bus.req_ready_i) state_d = WR_RSP;
            WR_RSP: begin
                if (bus.rsp_valid_i) begin
                    src_d = src_q + WORD_STEP;
                    dst_d = dst_q + WORD_STEP;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_d == '0) state_d = FIN;
                    else if (fill_q) state_d = WR_REQ;
                    else             state_d = RD_REQ;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered from the next state so a request appears the
        // cycle after the decision and stays frozen until its handshake.
        req_valid_d = (state_d == RD_REQ) || (state_d == WR_REQ);
        rsp_ready_d = (state_d == RD_RSP) || (state_d == WR_RSP);
        done_d      = (state_q == FIN);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        if (state_d == RD_REQ) begin
            addr_d = src_d;
            we_d   = 1'b0;
        end else if (state_d == WR_REQ) begin
            addr_d  = dst_d;
            we_d    = 1'b1;
            wdata_d = buf_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            req_valid_q <= 1'b0;
            rsp_ready_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_q      <= fill_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            req_valid_q <= req_valid_d;
            rsp_ready_q <= rsp_ready_d;
            done_q      <= done_d;
        end
    end

    // Transfer bookkeeping is always reloaded at start, so it needs no reset.
    always_ff @(posedge clk) begin
        src_q <= src_d;
        dst_q <= dst_d;
        cnt_q <= cnt_d;
        buf_q <= buf_d;
    end

    assign busy_o          = (state_q != IDLE);
    assign done_o          = done_q;
    assign bus.addr_o      = addr_q;
    assign bus.data_o      = wdata_q;
    assign bus.sel_o       = 4'hF;
    assign bus.we_o        = we_q;
    assign bus.req_valid_o = req_valid_q;
    assign bus.rsp_ready_o = rsp_ready_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Scoreboard bench for bus_dma_master: a reference copy model queues expected bus
// transactions and done cycles; a monitor compares them as the DUT presents them.
module tb_bus_dma_master;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] src_addr_i = '0;
    logic [31:0] dst_addr_i = '0;
    logic [15:0] len_i = '0;
    logic        busy_o, done_o;
`ifdef DMA_FILL_EN
    logic        fill_i = 1'b0;
    logic [31:0] pattern_i = '0;
`endif

    bus_dma_master_if #(.ADDR_W(ADDR_W)) bus ();

    bus_dma_master #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .src_addr_i (src_addr_i),
        .dst_addr_i (dst_addr_i),
        .len_i      (len_i),
`ifdef DMA_FILL_EN
        .fill_i     (fill_i),
        .pattern_i  (pattern_i),
`endif
        .busy_o     (busy_o),
        .done_o     (done_o),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    int          done_q[$];
    string       cq_nm[$];
    logic [31:0] cq_act[$];
    logic [31:0] cq_exp[$];
    int          n_cmp = 0;
    int          n_fail = 0;

    logic [31:0] smem [logic [31:0]];
    logic [31:0] rmem [logic [31:0]];
    int          bp_req = 0;
    int          bp_rsp = 0;

    function automatic logic [31:0] bg(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        if (rmem.exists(a)) return rmem[a];
        return bg(a);
    endfunction

    function automatic logic [31:0] rd_slv(input logic [31:0] a);
        if (smem.exists(a)) return smem[a];
        return bg(a);
    endfunction

    task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
        cq_nm.push_back(nm);
        cq_act.push_back(a);
        cq_exp.push_back(e);
    endtask

    function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, a, e);
        end
    endfunction

    // Slave: programmable request back-pressure and response delay.
    initial begin : slave
        logic        in_req, pend;
        int          wcnt, dly;
        logic [31:0] rdata;
        in_req = 1'b0; pend = 1'b0; wcnt = 0; dly = 0; rdata = '0;
        for (int i = 0; i < 4; i++) smem[32'h100 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
        bus.req_ready_i = 1'b0;
        bus.rsp_valid_i = 1'b0;
        bus.data_i      = '0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                in_req = 1'b0; pend = 1'b0;
                bus.req_ready_i = 1'b0;
                bus.rsp_valid_i = 1'b0;
            end else begin
                if (bus.req_valid_o && !in_req) begin
                    in_req = 1'b1;
                    wcnt   = bp_req;
                end
                if (in_req && wcnt == 0) bus.req_ready_i = 1'b1;
                else begin
                    bus.req_ready_i = 1'b0;
                    if (in_req) wcnt--;
                end
                if (pend && dly == 0) begin
                    bus.rsp_valid_i = 1'b1;
                    bus.data_i      = rdata;
                end else begin
                    bus.rsp_valid_i = 1'b0;
                    if (pend) dly--;
                end
            end
            @(negedge clk);
            if (!rst) begin
                if (bus.req_valid_o && bus.req_ready_i) begin
                    in_req = 1'b0;
                    pend   = 1'b1;
                    dly    = bp_rsp;
                    if (bus.we_o) smem[bus.addr_o] = bus.data_o;
                    else          rdata = rd_slv(bus.addr_o);
                end
                if (bus.rsp_valid_i && bus.rsp_ready_o) pend = 1'b0;
            end
        end
    end

    // Monitor: pops expectations when the DUT presents a request or done pulse.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr = '0, prev_data = '0;
    logic        prev_we = 1'b0;
    always @(negedge clk) begin
        while (cq_nm.size() > 0) chk(cq_nm.pop_front(), cq_act.pop_front(), cq_exp.pop_front());
        if (rst) begin
            exp_q.delete();
            done_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.req_valid_o), 32'd1);
                chk("hold_addr", bus.addr_o, prev_addr);
                chk("hold_data", bus.data_o, prev_data);
                chk("hold_we", 32'(bus.we_o), 32'(prev_we));
            end
            if (bus.req_valid_o && bus.req_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_req: got request addr %h we %0d, required none", bus.addr_o, bus.we_o);
                end else begin
                    txn_t e;
                    e = exp_q.pop_front();
                    chk("req_we", 32'(bus.we_o), 32'(e.we));
                    chk("req_addr", bus.addr_o, e.addr);
                    if (e.we) chk("req_data", bus.data_o, e.data);
                    chk("req_sel", 32'(bus.sel_o), 32'hF);
                end
            end
            if (done_o) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL extra_done: got done at cycle %0d, required none", cyc);
                end else begin
                    int d;
                    d = done_q.pop_front();
                    if (d >= 0) chk("done_cycle", cyc, 32'(d));
                end
            end
            prev_stall = bus.req_valid_o && !bus.req_ready_i;
            prev_addr  = bus.addr_o;
            prev_data  = bus.data_o;
            prev_we    = bus.we_o;
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_q.size() != 0) begin
            post("timeout_done", 32'(done_q.size()), 32'd0);
            done_q.delete();
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        post("txn_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic run_xfer(input logic [31:0] src, input logic [31:0] dst, input int len,
                            input bit fill, input logic [31:0] pat,
                            input int breq, input int brsp, input bit interfere);
        logic [31:0] s, d, v;
        int          lat;
        bit          zero_wait;
        bp_req = breq;
        bp_rsp = brsp;
        zero_wait = (breq == 0) && (brsp == 0);
        s = src & ~32'd3;
        d = dst & ~32'd3;
        for (int i = 0; i < len; i++) begin
            if (fill) v = pat;
            else begin
                v = rd_ref(s);
                exp_q.push_back('{we: 1'b0, addr: s, data: 32'h0});
            end
            exp_q.push_back('{we: 1'b1, addr: d, data: v});
            rmem[d] = v;
            s = s + 32'd4;
            d = d + 32'd4;
        end
        lat = fill ? (2 * len + 2) : (4 * len + 2);
        @(posedge clk); #2;
        src_addr_i = src;
        dst_addr_i = dst;
        len_i      = 16'(len);
`ifdef DMA_FILL_EN
        fill_i    = fill;
        pattern_i = pat;
`endif
        start_i = 1'b1;
        done_q.push_back(zero_wait ? int'(cyc) + lat : -1);
        @(posedge clk); #2;
        start_i    = 1'b0;
        src_addr_i = $urandom;
        dst_addr_i = $urandom;
        len_i      = 16'($urandom);
        if (interfere) begin
            repeat (5) @(posedge clk);
            #2 start_i = 1'b1;
            @(posedge clk); #2 start_i = 1'b0;
            repeat (6) @(posedge clk);
            #2 start_i = 1'b1; src_addr_i = 32'h0000_0F00; len_i = 16'd1;
            @(posedge clk); #2 start_i = 1'b0;
        end
        wait_done(600);
        d = dst & ~32'd3;
        for (int i = 0; i < len; i++) begin
            post("mem_word", rd_slv(d), rd_ref(d));
            d = d + 32'd4;
        end
    endtask

    task automatic rst_test();
        int n;
        bp_req = 3;
        bp_rsp = 0;
        exp_q.push_back('{we: 1'b0, addr: 32'h300, data: 32'h0});
        exp_q.push_back('{we: 1'b1, addr: 32'h400, data: rd_ref(32'h300)});
        @(posedge clk); #2;
        src_addr_i = 32'h300; dst_addr_i = 32'h400; len_i = 16'd3;
        start_i = 1'b1;
        done_q.push_back(-1);
        @(posedge clk); #2 start_i = 1'b0;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.req_valid_o && bus.we_o && !bus.req_ready_i) break;
            n++;
        end
        post("reach_wr_req", 32'(n < 200), 32'd1);
        #2 rst = 1'b1;
        #1;
        post("rst_busy", 32'(busy_o), 32'd0);
        post("rst_done", 32'(done_o), 32'd0);
        post("rst_addr", bus.addr_o, 32'd0);
        post("rst_data", bus.data_o, 32'd0);
        post("rst_we", 32'(bus.we_o), 32'd0);
        post("rst_req_valid", 32'(bus.req_valid_o), 32'd0);
        post("rst_rsp_ready", 32'(bus.rsp_ready_o), 32'd0);
        post("rst_sel", 32'(bus.sel_o), 32'hF);
        @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        post("post_rst_busy", 32'(busy_o), 32'd0);
    endtask

    initial begin : stim
        for (int i = 0; i < 4; i++) rmem[32'h100 + 32'(4 * i)] = 32'h1111_1111 * 32'(i + 1);
        repeat (2) @(posedge clk);
        #1;
        post("init_busy", 32'(busy_o), 32'd0);
        post("init_done", 32'(done_o), 32'd0);
        post("init_addr", bus.addr_o, 32'd0);
        post("init_req_valid", 32'(bus.req_valid_o), 32'd0);
        post("init_rsp_ready", 32'(bus.rsp_ready_o), 32'd0);
        post("init_sel", 32'(bus.sel_o), 32'hF);
        @(negedge clk); #2 rst = 1'b0;

        run_xfer(32'h100, 32'h200, 4, 1'b0, 32'h0, 0, 0, 1'b0);
        run_xfer(32'h100, 32'h200, 0, 1'b0, 32'h0, 0, 0, 1'b0);
        run_xfer(32'h101, 32'h602, 4, 1'b0, 32'h0, 3, 2, 1'b0);
        run_xfer(32'h800, 32'h900, 5, 1'b0, 32'h0, 0, 0, 1'b1);
        run_xfer(32'hFFFF_FFFC, 32'h500, 2, 1'b0, 32'h0, 0, 0, 1'b0);
        rst_test();
`ifdef DMA_FILL_EN
        run_xfer(32'h0, 32'h700, 3, 1'b1, 32'hDEAD_BEEF, 0, 0, 1'b0);
`endif
        for (int k = 0; k < 10; k++) begin
            logic [31:0] rs, rd;
            bit          rf;
            rs = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            rd = 32'h1000 + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
            rf = 1'b0;
`ifdef DMA_FILL_EN
            rf = 1'($urandom_range(0, 1));
`endif
            run_xfer(rs, rd, $urandom_range(0, 8), rf, $urandom,
                     $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
